// File: rtl/read_queue_pkg.sv
// Shared link constants and fill-state encodings for the narrow-to-wide read queue.
package read_queue_pkg;

    // Default leaf-to-leaf link widths, shared with the wide-to-narrow write queue.
    localparam int LINK_NARROW_W = 32;
    localparam int LINK_WIDE_W   = 512;

    // Fill state machine encodings: FILL while collecting beats 0..MAX-2,
    // LAST while waiting for the beat that completes the word.
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_LAST = 1'b1;

    // Number of narrow beats that make up one wide word.
    function automatic int beats_per_word(input int in_w, input int out_w);
        return out_w / in_w;
    endfunction

endpackage

// File: rtl/read_queue_if.sv
// Narrow input stream plus wide output stream of the read queue.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Ready never depends on valid. A producer may hold valid
// high for as long as it likes; data is only sampled on a transfer.
interface read_queue_if
    import read_queue_pkg::*;
#(
    parameter int IN_WIDTH  = LINK_NARROW_W,
    parameter int OUT_WIDTH = LINK_WIDE_W
) ();

    logic [IN_WIDTH-1:0]  din;
    logic                 vld_in;
    logic                 rdy_upward;
    logic [OUT_WIDTH-1:0] dout;
    logic                 vld_out;
    logic                 rdy_downward;

    // Environment side: drives narrow beats in, takes wide words out.
    modport master (
        output din, vld_in, rdy_downward,
        input  rdy_upward, dout, vld_out
    );

    // Deserializer side.
    modport slave (
        input  din, vld_in, rdy_downward,
        output rdy_upward, dout, vld_out
    );

endinterface

// File: rtl/read_queue.sv
// Narrow-to-wide deserializer: packs OUT_WIDTH/IN_WIDTH beats LSB-first into
// one wide word. The next word fills while the previous one waits at the
// output, so only the final beat of a word can ever be stalled.
module read_queue
    import read_queue_pkg::*;
#(
    parameter int IN_WIDTH  = LINK_NARROW_W,
    parameter int OUT_WIDTH = LINK_WIDE_W
) (
    input  logic        clk,
    input  logic        reset,          // asynchronous, active-low
    read_queue_if.slave bus,
    output logic [0:0]  dbg_state_o     // current fill state (ST_FILL / ST_LAST)
);

    localparam int               MAX      = beats_per_word(IN_WIDTH, OUT_WIDTH);
    localparam int               CNT_W    = $clog2(MAX);
    localparam int               ACC_W    = OUT_WIDTH - IN_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 out_full_q, out_full_d;
    logic [OUT_WIDTH-1:0] dout_q, dout_d;

    logic [0:0] state;
    logic       rdy;
    logic       acc_in;
    logic       acc_out;

    // The fill state is fully determined by the beat index.
    assign state = (cnt_q == LAST_IDX) ? ST_LAST : ST_FILL;

    // Only the completing beat can stall, and only while the previous word
    // is still pending and not being taken this cycle.
    assign rdy     = (state == ST_FILL) | ~out_full_q | bus.rdy_downward;
    assign acc_in  = bus.vld_in & rdy;
    assign acc_out = out_full_q & bus.rdy_downward;

    // Next-state: place beats into the accumulator, complete words into dout.
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dout_d     = dout_q;
        out_full_d = out_full_q;

        if (acc_out) begin
            out_full_d = 1'b0;
        end

        if (acc_in) begin
            if (state == ST_LAST) begin
                // acc is left as-is; its slots get overwritten by the next word.
                dout_d     = {bus.din, acc_q};
                out_full_d = 1'b1;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < MAX - 1; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        acc_d[i*IN_WIDTH +: IN_WIDTH] = bus.din;
                    end
                end
            end
        end
    end

    // State registers; reset discards partial beats and any pending word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            out_full_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_full_q <= out_full_d;
            dout_q     <= dout_d;
        end
    end

    assign bus.rdy_upward = rdy;
    assign bus.dout       = dout_q;
    assign bus.vld_out    = out_full_q;
    assign dbg_state_o    = state;

endmodule

// File: tb/tb_read_queue.sv
// Bench for read_queue: a 4-beat instance (32 -> 128) with a scoreboard,
// plus a default 32 -> 512 instance for the full-width packing.
module tb_read_queue;

    logic       clk;
    logic       reset;
    logic [0:0] dbg_state;
    logic [0:0] dbg_state_w;

    read_queue_if #(.IN_WIDTH(32), .OUT_WIDTH(128)) bus ();
    read_queue_if #(.IN_WIDTH(32), .OUT_WIDTH(512)) bus_w ();

    read_queue #(.IN_WIDTH(32), .OUT_WIDTH(128)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    read_queue #(.IN_WIDTH(32), .OUT_WIDTH(512)) u_dut_w (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_w),
        .dbg_state_o (dbg_state_w)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    logic [127:0] mdl_word;
    logic [127:0] exp_w;
    int           mdl_cnt   = 0;
    int           words_out = 0;
    int           last_pop  = -1;
    bit           strm_chk  = 0;

    // Sampled mid-cycle, so a handshake seen here is the one taken at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            mdl_cnt = 0;
            exp_q.delete();
        end else begin
            if (bus.vld_out && bus.rdy_downward) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_underflow", 512'(exp_q.size()), 512'(1));
                end else begin
                    exp_w = exp_q.pop_front();
                    check_val("sb_word", 512'(bus.dout), 512'(exp_w));
                    words_out++;
                    if (strm_chk && last_pop >= 0)
                        check_val("strm_period", 512'(cyc - last_pop), 512'(4));
                    last_pop = cyc;
                end
            end
            if (bus.vld_in && bus.rdy_upward) begin
                mdl_word[mdl_cnt*32 +: 32] = bus.din;
                mdl_cnt++;
                if (mdl_cnt == 4) begin
                    exp_q.push_back(mdl_word);
                    mdl_cnt = 0;
                end
            end
            if (strm_chk)
                check_val("strm_rdy", 512'(bus.rdy_upward), 512'(1));
        end
    end

    // ---------------- driver tasks ----------------
    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [31:0] d);
        int waits = 0;
        bus.vld_in = 1'b1;
        bus.din    = d;
        @(negedge clk);
        while (!bus.rdy_upward && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) check_val("beat_timeout", 512'(waits), 512'(0));
        @(posedge clk);
        #1;
        bus.vld_in = 1'b0;
        bus.din    = 'x;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    bit           bub_done;
    int           w0;
    logic [511:0] wexp;

    initial begin
        reset              = 1'b0;
        bus.vld_in         = 1'b0;
        bus.din            = '0;
        bus.rdy_downward   = 1'b0;
        bus_w.vld_in       = 1'b0;
        bus_w.din          = '0;
        bus_w.rdy_downward = 1'b0;

        // Reset state, observed while reset is held.
        #1;
        check_val("rst_rdy", 512'(bus.rdy_upward), 512'(1));
        check_val("rst_vld", 512'(bus.vld_out), 512'(0));
        check_val("rst_dout", 512'(bus.dout), 512'(0));
        check_val("rst_state", 512'(dbg_state), 512'(0));
        check_val("rst_w_rdy", 512'(bus_w.rdy_upward), 512'(1));
        check_val("rst_w_vld", 512'(bus_w.vld_out), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_val("post_rst_rdy", 512'(bus.rdy_upward), 512'(1));

        // Basic: four beats, word visible for exactly one cycle.
        bus.rdy_downward = 1'b1;
        send_beat(32'h11111111);
        send_beat(32'h22222222);
        send_beat(32'h33333333);
        check_val("basic_not_yet", 512'(bus.vld_out), 512'(0));
        send_beat(32'h44444444);
        @(negedge clk);
        check_val("basic_vld", 512'(bus.vld_out), 512'(1));
        check_val("basic_dout", 512'(bus.dout), 512'(128'h44444444_33333333_22222222_11111111));
        @(negedge clk);
        check_val("basic_one_cycle", 512'(bus.vld_out), 512'(0));

        // Backpressure: word1 held, beats 5..7 accepted, beat 8 stalled.
        @(posedge clk);
        #1;
        bus.rdy_downward = 1'b0;
        for (int i = 1; i <= 7; i++) send_beat(32'(i));
        check_val("bp_vld", 512'(bus.vld_out), 512'(1));
        check_val("bp_hold", 512'(bus.dout), 512'({32'd4, 32'd3, 32'd2, 32'd1}));
        check_val("bp_state", 512'(dbg_state), 512'(1));
        bus.vld_in = 1'b1;
        bus.din    = 32'd8;
        @(negedge clk);
        check_val("bp_stall", 512'(bus.rdy_upward), 512'(0));
        @(negedge clk);
        check_val("bp_stall2", 512'(bus.rdy_upward), 512'(0));
        check_val("bp_hold2", 512'(bus.dout), 512'({32'd4, 32'd3, 32'd2, 32'd1}));
        @(posedge clk);
        #1;
        bus.rdy_downward = 1'b1;
        @(negedge clk);
        check_val("bp_release", 512'(bus.rdy_upward), 512'(1));
        @(posedge clk);
        #1;
        bus.vld_in       = 1'b0;
        bus.din          = 'x;
        bus.rdy_downward = 1'b0;
        @(negedge clk);
        check_val("bp_w2_vld", 512'(bus.vld_out), 512'(1));
        check_val("bp_w2_dout", 512'(bus.dout), 512'({32'd8, 32'd7, 32'd6, 32'd5}));
        @(posedge clk);
        #1;
        bus.rdy_downward = 1'b1;
        @(posedge clk);
        #1;

        // Streaming: 64 beats at full rate, 16 words one every 4 cycles.
        w0       = words_out;
        last_pop = -1;
        strm_chk = 1;
        for (int i = 0; i < 64; i++) send_beat($urandom);
        strm_chk = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("strm_words", 512'(words_out - w0), 512'(16));

        // Bubbles: random input gaps and random output backpressure.
        w0       = words_out;
        bub_done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        @(posedge clk);
                        #1;
                    end
                    send_beat($urandom);
                end
                bub_done = 1;
            end
            begin
                while (!bub_done) begin
                    @(posedge clk);
                    #1;
                    bus.rdy_downward = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.rdy_downward = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("bub_drain", 512'(exp_q.size()), 512'(0));
        check_val("bub_words", 512'(words_out - w0), 512'(15));

        // Reset mid-word: partial beats are discarded.
        send_beat(32'hdead0001);
        send_beat(32'hdead0002);
        pulse_reset();
        check_val("rmw_state", 512'(dbg_state), 512'(0));
        send_beat(32'haaaaaaaa);
        send_beat(32'hbbbbbbbb);
        send_beat(32'hcccccccc);
        send_beat(32'hdddddddd);
        @(negedge clk);
        check_val("rmw_vld", 512'(bus.vld_out), 512'(1));
        check_val("rmw_dout", 512'(bus.dout), 512'(128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa));
        @(posedge clk);
        #1;

        // Reset with a pending word: dropped immediately.
        bus.rdy_downward = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'h5a5a0000 | 32'(i));
        @(negedge clk);
        check_val("rpend_vld", 512'(bus.vld_out), 512'(1));
        reset = 1'b0;
        #1;
        check_val("rpend_async_vld", 512'(bus.vld_out), 512'(0));
        check_val("rpend_async_dout", 512'(bus.dout), 512'(0));
        check_val("rpend_rdy", 512'(bus.rdy_upward), 512'(1));
        @(posedge clk);
        #1;
        reset            = 1'b1;
        bus.rdy_downward = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rpend_no_ghost", 512'(bus.vld_out), 512'(0));

        // Default 512-bit instance: two full-rate words.
        bus_w.rdy_downward = 1'b1;
        wexp = '0;
        for (int i = 0; i < 32; i++) begin
            bus_w.vld_in = 1'b1;
            bus_w.din    = $urandom;
            wexp[(i % 16)*32 +: 32] = bus_w.din;
            @(negedge clk);
            check_val("wide_rdy", 512'(bus_w.rdy_upward), 512'(1));
            @(posedge clk);
            #1;
            if (i % 16 == 15) begin
                check_val("wide_vld", 512'(bus_w.vld_out), 512'(1));
                check_val("wide_dout", bus_w.dout, wexp);
            end else if (i % 16 == 0) begin
                check_val("wide_vld_low", 512'(bus_w.vld_out), 512'(0));
            end
        end
        bus_w.vld_in = 1'b0;
        bus_w.din    = 'x;
        @(posedge clk);
        #1;
        check_val("wide_taken", 512'(bus_w.vld_out), 512'(0));

        check_val("final_sb_empty", 512'(exp_q.size()), 512'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/read_queue.md
Name: read_queue

Overview:
- Narrow-to-wide deserializer: collects MAX = OUT_WIDTH/IN_WIDTH narrow beats from a valid/ready stream and emits one wide word.
- Inverse of the team's wide-to-narrow write queue; sits on the receive side of the 32-bit leaf-to-leaf links, feeding 512-bit consumers (DMA/memory-side logic).
- Beat order is LSB-first: beat 0 lands in dout[IN_WIDTH-1:0].
- Sustains 1 beat/cycle: the next word fills while the previous word waits at the output.

Parameters:
- IN_WIDTH, 32, narrow input beat width.
- OUT_WIDTH, 512, wide output word width. Must be an integer multiple of IN_WIDTH with MAX >= 2.
- MAX, OUT_WIDTH/IN_WIDTH (localparam), beats per word.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- din  in  IN_WIDTH  narrow input beat.
- vld_in  in  1  din valid.
- rdy_upward  out  1  block can accept din this cycle.
- dout  out  OUT_WIDTH  assembled wide word.
- vld_out  out  1  dout valid.
- rdy_downward  in  1  consumer accepts dout this cycle.

Behaviour:
- Handshake events:
  - acc_in = vld_in & rdy_upward.
  - acc_out = vld_out & rdy_downward.
  - Producer may hold vld_in high indefinitely; din is sampled only on acc_in.
- State:
  - cnt (0..MAX-1): index of the next beat.
  - acc register, OUT_WIDTH-IN_WIDTH bits, holding beats 0..MAX-2.
  - out_full flag, driving vld_out.
  - dout register.
- Fill state machine (states: FILL when cnt<MAX-1, LAST when cnt==MAX-1):
  - FILL, acc_in: acc slot cnt <= din; cnt <= cnt+1. Enter LAST when cnt reaches MAX-1.
  - LAST, acc_in: dout <= {din, acc}; out_full <= 1; cnt <= 0; return to FILL. acc is not cleared; stale slots are overwritten beat by beat.
  - No acc_in: cnt and acc hold.
- Ready (combinational; no registered stage): rdy_upward = (cnt != MAX-1) | ~out_full | rdy_downward.
  - Only the final beat of a word stalls, and only while the previous word is pending and not being taken.
  - rdy_upward must not depend on vld_in.
- Output:
  - vld_out = out_full. dout is registered and stable while vld_out=1 and rdy_downward=0.
  - acc_out with no completion in the same cycle: out_full <= 0, and dout holds its old value.
  - acc_out and completion in the same cycle: out_full stays 1 and dout takes the new word (back-to-back words, no bubble).
- Latency: vld_out rises the cycle after the final beat is accepted. Minimum word period is MAX cycles.
- Reset (asynchronous assert, takes effect immediately; deassertion is synchronized externally):
  - cnt=0, acc=0, out_full=0, dout=0, vld_out=0.
  - rdy_upward=1 during and after reset.
  - Reset mid-word discards the partial beats. Reset with a pending word drops that word; no partial word is ever emitted.
- Boundaries:
  - vld_in low in the middle of a word: the word pauses with no timeout.
  - rdy_downward high while vld_out=0 has no effect.
  - X on din when acc_in=0 must not propagate into state.

Decomposition:
- Shared constants header holds the default link widths (32 narrow, 512 wide). These are shared with the write queue.
- No sub-module is needed. cnt, acc, out_full and dout live in a single module of about 150 lines.

Test Plan:
- Use OUT_WIDTH=128 (MAX=4) and the 512 default.
- Basic: after reset, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles with rdy_downward=1 -> at cycle 5, vld_out=1 and dout=0x44444444_33333333_22222222_11111111 for exactly 1 cycle.
- Backpressure: rdy_downward=0 and 8 beats 1..8 streamed -> word1 held stable; beats 5,6,7 accepted; rdy_upward=0 on beat 8. Raise rdy_downward -> word1 taken; beat 8 accepted the same cycle; next cycle dout=0x8_7_6_5 (32-bit fields), vld_out=1.
- Streaming: 64 beats with vld_in and rdy_downward held high -> rdy_upward never drops; 16 words out, one every 4 cycles; data matches the LSB-first packing.
- Bubbles: random vld_in gaps (50%) and random rdy_downward -> scoreboard matches every word; no loss, no duplicates.
- Reset mid-word: accept 2 beats, assert reset for 1 cycle, then send 4 beats A,B,C,D -> single word D_C_B_A; the earlier beats never appear.
- Reset with pending output: word pending with rdy_downward=0, pulse reset -> vld_out=0 immediately (asynchronous) and dout=0.
